// File: rtl/delay_meas_pkg.sv
// Shared types, defaults and sizing helper for the delay_meas loop-back latency calibrator.
package delay_meas_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FLUSH  = 3'd1,
        ST_PROBE  = 3'd2,
        ST_WAIT   = 3'd3,
        ST_FINISH = 3'd4
    } state_e;

    localparam int unsigned DEFAULT_DW        = 8;
    localparam logic [63:0] DEFAULT_MARKER    = '1;
    localparam logic [63:0] DEFAULT_IDLE_WORD = '0;

    // Width of the beat counter and of meas_len: must hold 0..max_len.
    function automatic int unsigned len_width(input int unsigned max_len);
        return $clog2(max_len + 1);
    endfunction

endpackage

// File: rtl/delay_meas.sv
// Loop-back latency calibrator: launches MARKER into an enable-qualified path and reports its delay in beats.
// Optional double-measurement consistency check enabled by `define DELAY_MEAS_VERIFY_EN.
module delay_meas
    import delay_meas_pkg::*;
#(
    parameter int unsigned    DW        = DEFAULT_DW,
    parameter int unsigned    MAX_LEN   = 32,
    parameter logic [DW-1:0]  MARKER    = DW'(DEFAULT_MARKER),
    parameter logic [DW-1:0]  IDLE_WORD = DW'(DEFAULT_IDLE_WORD)
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            en,
    input  logic                            start,
    input  logic [DW-1:0]                   din_ret,
    output logic [DW-1:0]                   probe_out,
    output logic                            busy,
    output logic                            done,
    output logic                            timeout,
    output logic [len_width(MAX_LEN)-1:0]   meas_len
`ifdef DELAY_MEAS_VERIFY_EN
    ,
    output logic                            mismatch
`endif
);

    localparam int unsigned   LW      = len_width(MAX_LEN);
    localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

    if (MARKER == IDLE_WORD) begin : g_cfg_check
        $error("delay_meas: MARKER must differ from IDLE_WORD");
    end

    state_e         state_q;
    logic [LW-1:0]  cnt_q;
    logic [LW-1:0]  len_q;
    logic [DW-1:0]  probe_q;
    logic           busy_q;
    logic           done_q;
    logic           timeout_q;
    logic           hit_c;

`ifdef DELAY_MEAS_VERIFY_EN
    logic           second_q;
    logic           mismatch_q;
    assign mismatch = mismatch_q;
`endif

    assign hit_c = (din_ret == MARKER);

    // PROBE and WAIT share one branch: PROBE always runs with cnt_q == 0,
    // so cnt_q is the delay in both states.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            len_q     <= '0;
            probe_q   <= IDLE_WORD;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            timeout_q <= 1'b0;
`ifdef DELAY_MEAS_VERIFY_EN
            second_q   <= 1'b0;
            mismatch_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    probe_q <= IDLE_WORD;
                    if (start) begin
                        state_q   <= ST_FLUSH;
                        busy_q    <= 1'b1;
                        cnt_q     <= '0;
                        len_q     <= '0;
                        timeout_q <= 1'b0;
`ifdef DELAY_MEAS_VERIFY_EN
                        second_q   <= 1'b0;
                        mismatch_q <= 1'b0;
`endif
                    end
                end
                ST_FLUSH: begin
                    if (en) begin
                        if (cnt_q == LEN_MAX) begin
                            state_q <= ST_PROBE;
                            cnt_q   <= '0;
                            probe_q <= MARKER;
                        end else begin
                            cnt_q <= cnt_q + LW'(1);
                        end
                    end
                end
                ST_PROBE, ST_WAIT: begin
                    if (en) begin
                        probe_q <= IDLE_WORD;
                        if (hit_c) begin
`ifdef DELAY_MEAS_VERIFY_EN
                            if (!second_q) begin
                                len_q    <= cnt_q;
                                second_q <= 1'b1;
                                state_q  <= ST_PROBE;
                                cnt_q    <= '0;
                                probe_q  <= MARKER;
                            end else begin
                                mismatch_q <= (cnt_q != len_q);
                                state_q    <= ST_FINISH;
                                done_q     <= 1'b1;
                            end
`else
                            len_q   <= cnt_q;
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
`endif
                        end else if (state_q == ST_WAIT && cnt_q == LEN_MAX) begin
`ifdef DELAY_MEAS_VERIFY_EN
                            if (second_q) begin
                                mismatch_q <= 1'b1;
                            end else begin
                                timeout_q <= 1'b1;
                            end
`else
                            timeout_q <= 1'b1;
`endif
                            state_q <= ST_FINISH;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= ST_WAIT;
                            cnt_q   <= cnt_q + LW'(1);
                        end
                    end
                end
                ST_FINISH: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    probe_q <= IDLE_WORD;
                end
            endcase
        end
    end

    assign probe_out = probe_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign timeout   = timeout_q;
    assign meas_len  = len_q;

endmodule
